// File: rtl/acc_arb_pkg.sv
// Shared types and defaults for the accumulator load arbiter.
// The LOCKED state is used only when ACC_ARB_LOCK_EN is defined.
package acc_arb_pkg;

    localparam int unsigned ACC_DATA_W    = 8;
    localparam int unsigned DEFAULT_N_REQ = 4;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StLoad   = 2'd1,
        StLocked = 2'd2
    } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: the first valid requester found scanning
// from rr_ptr upward, modulo N_REQ.
module rr_pick #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned GNT_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_valid,
    input  logic [GNT_W-1:0] rr_ptr,
    output logic [GNT_W-1:0] winner,
    output logic             any_valid
);

    // Scan every rotation offset; the first hit is kept.
    always_comb begin
        logic              found;
        int unsigned       idx_full;
        logic [GNT_W-1:0]  idx;
        winner   = '0;
        found    = 1'b0;
        idx_full = 0;
        idx      = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            idx_full = (32'(rr_ptr) + k) % N_REQ;
            idx      = GNT_W'(idx_full);
            if (!found && req_valid[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    assign any_valid = |req_valid;

endmodule

// File: rtl/acc_load_arbiter.sv
// Round-robin arbiter for the accumulator load port. A grant is taken in IDLE,
// the load pulse and the requester's ready pulse are issued in the following
// LOAD cycle. Optional feature: define ACC_ARB_LOCK_EN to add the req_lock port
// and the LOCKED state, which keeps the port reserved for the current winner.
module acc_load_arbiter
    import acc_arb_pkg::*;
#(
    parameter int unsigned N_REQ  = DEFAULT_N_REQ,
    parameter int unsigned DATA_W = ACC_DATA_W,
    localparam int unsigned GNT_W = $clog2(N_REQ)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*DATA_W-1:0] req_data,
`ifdef ACC_ARB_LOCK_EN
    input  logic [N_REQ-1:0]        req_lock,
`endif
    output logic [N_REQ-1:0]        req_ready,
    output logic                    acc_load,
    output logic [DATA_W-1:0]       acc_data,
    output logic [GNT_W-1:0]        grant_id,
    output logic                    busy
);

    arb_state_e        state_q, state_d;
    logic [GNT_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [GNT_W-1:0]  grant_q, grant_d;
    logic [DATA_W-1:0] data_q, data_d;

    logic [GNT_W-1:0]  winner;
    logic              any_valid;
    logic [GNT_W-1:0]  ptr_after_grant;
    logic [DATA_W-1:0] req_words [N_REQ];

    // Split the flat data bus into one word per requester.
    for (genvar i = 0; i < N_REQ; i++) begin : g_words
        assign req_words[i] = req_data[i*DATA_W +: DATA_W];
    end

    rr_pick #(
        .N_REQ (N_REQ),
        .GNT_W (GNT_W)
    ) u_rr_pick (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr_q),
        .winner    (winner),
        .any_valid (any_valid)
    );

    // Pointer moves just past the last winner, wrapping N_REQ-1 -> 0.
    always_comb begin
        if (grant_q == GNT_W'(N_REQ - 1)) begin
            ptr_after_grant = '0;
        end else begin
            ptr_after_grant = grant_q + 1'b1;
        end
    end

    // Next-state logic: grant capture in IDLE, pointer advance on leaving LOAD.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        grant_d  = grant_q;
        data_d   = data_q;
        unique case (state_q)
            StIdle: begin
                if (any_valid) begin
                    grant_d = winner;
                    data_d  = req_words[winner];
                    state_d = StLoad;
                end
            end
            StLoad: begin
`ifdef ACC_ARB_LOCK_EN
                if (req_lock[grant_q]) begin
                    // Keep the port for this requester; pointer stays put.
                    state_d = StLocked;
                end else begin
                    state_d  = StIdle;
                    rr_ptr_d = ptr_after_grant;
                end
`else
                state_d  = StIdle;
                rr_ptr_d = ptr_after_grant;
`endif
            end
`ifdef ACC_ARB_LOCK_EN
            StLocked: begin
                if (req_valid[grant_q]) begin
                    data_d  = req_words[grant_q];
                    state_d = StLoad;
                end else if (!req_lock[grant_q]) begin
                    state_d  = StIdle;
                    rr_ptr_d = ptr_after_grant;
                end
            end
`endif
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers; reset aborts any load in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            data_q   <= data_d;
        end
    end

    // Outputs decode only registered state, so no path from req_valid.
    always_comb begin
        acc_load  = (state_q == StLoad);
        req_ready = acc_load ? (N_REQ'(1) << grant_q) : '0;
        busy      = (state_q != StIdle);
    end

    assign acc_data = data_q;
    assign grant_id = grant_q;

endmodule

// File: tb/tb_acc_load_arbiter.sv
// Self-checking bench for acc_load_arbiter: directed vector table, hand-written
// reset/idle/lock sequences, and randomized traffic against a reference model.
module tb_acc_load_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_data;
`ifdef ACC_ARB_LOCK_EN
    logic [N-1:0]    req_lock;
`endif
    logic [N-1:0]    req_ready;
    logic            acc_load;
    logic [DW-1:0]   acc_data;
    logic [1:0]      grant_id;
    logic            busy;

    always #5 clk = ~clk;

    acc_load_arbiter #(
        .N_REQ  (N),
        .DATA_W (DW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
`ifdef ACC_ARB_LOCK_EN
        .req_lock  (req_lock),
`endif
        .req_ready (req_ready),
        .acc_load  (acc_load),
        .acc_data  (acc_data),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: pending grant flag, pointer, winner and captured word.
    int         m_ptr, m_grant;
    bit         m_load;
    logic [7:0] m_data;

    typedef struct {
        logic [N-1:0]    v;
        logic [N*DW-1:0] d;
        bit              e_load;
        logic [N-1:0]    e_ready;
        logic [DW-1:0]   e_data;
        logic [1:0]      e_grant;
        bit              e_busy;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input bit el, input logic [N-1:0] er,
                           input logic [DW-1:0] ed, input logic [1:0] eg, input bit eb);
        chk({tag, ".acc_load"},  32'(acc_load),  32'(el));
        chk({tag, ".req_ready"}, 32'(req_ready), 32'(er));
        chk({tag, ".acc_data"},  32'(acc_data),  32'(ed));
        chk({tag, ".grant_id"},  32'(grant_id),  32'(eg));
        chk({tag, ".busy"},      32'(busy),      32'(eb));
    endtask

    task automatic model_reset();
        m_ptr = 0; m_grant = 0; m_load = 0; m_data = '0;
    endtask

    // One clock edge of the arbitration rules.
    task automatic model_edge(input logic [N-1:0] v, input logic [N*DW-1:0] d);
        if (m_load) begin
            m_ptr  = (m_grant + 1) % N;
            m_load = 0;
        end else if (v != '0) begin
            for (int k = 0; k < N; k++) begin
                int i;
                i = (m_ptr + k) % N;
                if (v[i]) begin
                    m_grant = i;
                    m_data  = d[i*DW +: DW];
                    m_load  = 1;
                    break;
                end
            end
        end
    endtask

    task automatic chk_model(input string tag);
        chk_all(tag, m_load, m_load ? N'(1 << m_grant) : '0, m_data, 2'(m_grant), m_load);
    endtask

    // Inputs change at the falling edge; outputs are sampled at the next one.
    task automatic drive(input logic [N-1:0] v, input logic [N*DW-1:0] d);
        req_valid = v;
        req_data  = d;
        @(posedge clk);
        model_edge(v, d);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        req_valid = '0;
`ifdef ACC_ARB_LOCK_EN
        req_lock  = '0;
`endif
        repeat (2) @(negedge clk);
        model_reset();
        reset = 1'b1;
    endtask

    initial begin
        reset     = 1'b0;
        req_valid = '0;
        req_data  = '0;
`ifdef ACC_ARB_LOCK_EN
        req_lock  = '0;
`endif
        vecs[0]  = '{4'b0100, 32'h00A5_0000, 1, 4'b0100, 8'hA5, 2'd2, 1};
        vecs[1]  = '{4'b0100, 32'h00A5_0000, 0, 4'b0000, 8'hA5, 2'd2, 0};
        vecs[2]  = '{4'b1001, 32'h1100_0022, 1, 4'b1000, 8'h11, 2'd3, 1};
        vecs[3]  = '{4'b1001, 32'h3300_0022, 0, 4'b0000, 8'h11, 2'd3, 0};
        vecs[4]  = '{4'b1111, 32'hC3C2_C1C0, 1, 4'b0001, 8'hC0, 2'd0, 1};
        vecs[5]  = '{4'b1111, 32'hC3C2_C1C0, 0, 4'b0000, 8'hC0, 2'd0, 0};
        vecs[6]  = '{4'b1111, 32'hC3C2_C1C0, 1, 4'b0010, 8'hC1, 2'd1, 1};
        vecs[7]  = '{4'b1111, 32'hC3C2_C1C0, 0, 4'b0000, 8'hC1, 2'd1, 0};
        vecs[8]  = '{4'b1111, 32'hC3C2_C1C0, 1, 4'b0100, 8'hC2, 2'd2, 1};
        vecs[9]  = '{4'b1111, 32'hC3C2_C1C0, 0, 4'b0000, 8'hC2, 2'd2, 0};
        vecs[10] = '{4'b1111, 32'hC3C2_C1C0, 1, 4'b1000, 8'hC3, 2'd3, 1};
        vecs[11] = '{4'b1111, 32'hC3C2_C1C0, 0, 4'b0000, 8'hC3, 2'd3, 0};
        vecs[12] = '{4'b1111, 32'hC3C2_C1C0, 1, 4'b0001, 8'hC0, 2'd0, 1};
        vecs[13] = '{4'b1111, 32'hC3C2_C1C0, 0, 4'b0000, 8'hC0, 2'd0, 0};

        repeat (2) @(negedge clk);
        chk_all("reset", 0, 4'b0000, 8'h00, 2'd0, 0);
        model_reset();
        reset = 1'b1;

        // Single grant, wrap from pointer 3, ignored late data, full rotation.
        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].v, vecs[i].d);
            chk_all($sformatf("vec%0d", i), vecs[i].e_load, vecs[i].e_ready,
                    vecs[i].e_data, vecs[i].e_grant, vecs[i].e_busy);
        end

        // Long idle: nothing loads and the last word is held.
        for (int i = 0; i < 20; i++) begin
            drive('0, $urandom);
            chk_all("idle", 0, 4'b0000, 8'hC0, 2'd0, 0);
        end

        // Reset during LOAD aborts the load; the request is served again after.
        drive(4'b0001, 32'h0000_005A);
        chk("midreset.load_before", 32'(acc_load), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("midreset.acc_load", 32'(acc_load), 32'd0);
        chk("midreset.req_ready", 32'(req_ready), 32'd0);
        chk("midreset.busy", 32'(busy), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        drive(4'b0001, 32'h0000_005A);
        chk_all("regrant", 1, 4'b0001, 8'h5A, 2'd0, 1);
        drive('0, '0);

`ifdef ACC_ARB_LOCK_EN
        begin
            int loads;
            bit served;
            do_reset();
            req_lock = 4'b0010;
            drive(4'b0010, 32'h0000_5100);
            chk("lock.first_grant", 32'(grant_id), 32'd1);
            loads = acc_load ? 1 : 0;
            for (int i = 0; i < 5; i++) begin
                drive(4'b0011, 32'h0000_5177);
                if (acc_load) begin
                    loads++;
                    chk("lock.ready", 32'(req_ready), 32'b0010);
                end
            end
            chk("lock.load_count", loads, 3);
            req_lock = '0;
            served = 0;
            for (int i = 0; i < 6; i++) begin
                drive(4'b0001, 32'h0000_0077);
                if (acc_load) begin
                    chk("lock.after_ready", 32'(req_ready), 32'b0001);
                    served = 1;
                    break;
                end
            end
            chk("lock.zero_served", 32'(served), 32'd1);
        end
`endif

        // Randomized traffic against the model, valid free to drop any time.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            logic [N-1:0] v;
            v = (($urandom % 4) == 0) ? '0 : N'($urandom);
            drive(v, $urandom);
            chk_model("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
